// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, widths and default configuration for the PLL reset
// sequencer and its clk_out1 frequency meter.
package pll_seq_pkg;

    // Width of the edge count and of the last-window result.
    localparam int unsigned MeasW = 11;
    // Deviation compare is done one bit wider so it can be signed.
    localparam int unsigned CmpW  = MeasW + 1;

    localparam int unsigned DefNDom     = 4;
    localparam int unsigned DefStabCyc  = 256;
    localparam int unsigned DefStageGap = 16;
    localparam int unsigned DefWinCyc   = 1024;
    // clk_out1 toggle edges seen in 1024 cycles of 200 MHz at 180 MHz: 1024 * 180 / 200 = 921.6
    localparam int unsigned DefExpEdges = 922;
    localparam int unsigned DefTol      = 8;
    localparam int unsigned DefMaxRetry = 3;
    localparam int unsigned DefGuardCyc = 64;

    typedef enum logic [2:0] {
        StWaitLock,
        StStab,
        StMeas,
        StRel,
        StRun,
        StPllRst,
        StFault
    } state_e;

endpackage

// File: rtl/pll_freq_meter.sv
// pll_freq_meter: counts transitions of the clk_out1 toggle flop over a fixed window of clk_out0
// cycles and flags whether the count lies within tolerance of the expected value. Windows run
// back-to-back while en_i is high; everything clears while en_i is low.
module pll_freq_meter
    import pll_seq_pkg::*;
#(
    parameter int unsigned WinCyc   = DefWinCyc,
    parameter int unsigned ExpEdges = DefExpEdges,
    parameter int unsigned Tol      = DefTol
) (
    input  logic             clk_out0,
    input  logic             arst_n,
    input  logic             en_i,
    input  logic             tgl_i,
    output logic             win_done_o,
    output logic             win_pass_o,
    output logic [MeasW-1:0] count_o
);

    localparam int unsigned WinW = $clog2(WinCyc);

    logic                  tgl_meta_q, tgl_s_q, tgl_prev_q;
    logic                  edge_now;
    logic [MeasW-1:0]      edge_q, edge_d;
    logic [WinW-1:0]       win_q, win_d;
    logic signed [CmpW-1:0] diff, mag;

    // Synchronise the toggle and keep one extra stage to detect either transition.
    always_ff @(posedge clk_out0 or negedge arst_n) begin
        if (!arst_n) begin
            tgl_meta_q <= 1'b0;
            tgl_s_q    <= 1'b0;
            tgl_prev_q <= 1'b0;
        end else begin
            tgl_meta_q <= tgl_i;
            tgl_s_q    <= tgl_meta_q;
            tgl_prev_q <= tgl_s_q;
        end
    end

    assign edge_now   = tgl_s_q ^ tgl_prev_q;
    // Count including this cycle's edge, saturating at all-ones.
    assign count_o    = (edge_q == '1) ? edge_q : edge_q + MeasW'(edge_now);
    assign win_done_o = en_i && (win_q == WinW'(WinCyc - 1));

    assign diff       = $signed({1'b0, count_o}) - $signed(CmpW'(ExpEdges));
    assign mag        = diff[CmpW-1] ? -diff : diff;
    assign win_pass_o = mag <= $signed(CmpW'(Tol));

    // Advance the window and edge counters; restart both at window end or when disabled.
    always_comb begin
        win_d  = win_q + WinW'(1);
        edge_d = count_o;
        if (!en_i || win_done_o) begin
            win_d  = '0;
            edge_d = '0;
        end
    end

    // Window and edge counter registers.
    always_ff @(posedge clk_out0 or negedge arst_n) begin
        if (!arst_n) begin
            win_q  <= '0;
            edge_q <= '0;
        end else begin
            win_q  <= win_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/pll_rst_sequencer.sv
// pll_rst_sequencer: holds the downstream clock domains in reset until the PLL is locked and
// settled, then releases srst_o[0..N_DOM-1] in order and keeps watching lock.
// Build option PLL_FREQ_MON_EN: adds the clk_out1 frequency check before release and during
// run, with PLL reset requests, bounded retries and a sticky fault.
module pll_rst_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned N_DOM     = DefNDom,
    parameter int unsigned STAB_CYC  = DefStabCyc,
    parameter int unsigned STAGE_GAP = DefStageGap,
    parameter int unsigned WIN_CYC   = DefWinCyc,
    parameter int unsigned EXP_EDGES = DefExpEdges,
    parameter int unsigned TOL       = DefTol,
    parameter int unsigned MAX_RETRY = DefMaxRetry,
    parameter int unsigned GUARD_CYC = DefGuardCyc
) (
    input  logic             clk_out0,
    input  logic             arst_n,
    input  logic             pll_lock,
    input  logic             clk_mon_tgl,
    input  logic             clr_fault,
    output logic [N_DOM-1:0] srst_o,
    output logic             ready,
    output logic             pll_rst_req,
    output logic             fault,
    output logic [1:0]       retry_cnt,
    output logic [MeasW-1:0] meas_cnt
);

    localparam int unsigned CntW = 16;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             lock_meta_q, lock_s_q;
    logic [N_DOM-1:0] srst_q, srst_d;
    logic             ready_q, ready_d;
    logic             req_q, req_d;
    logic             fault_q, fault_d;
    logic [1:0]       retry_q, retry_d;
    logic [MeasW-1:0] meas_q, meas_d;
    logic             win_done, win_pass;
    logic [MeasW-1:0] win_count;
    state_e           fail_state;

    // Two-flop synchroniser for the asynchronous PLL LOCKED signal.
    always_ff @(posedge clk_out0 or negedge arst_n) begin
        if (!arst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

`ifdef PLL_FREQ_MON_EN
    localparam bit MonEn = 1'b1;
    logic meter_en;

    assign meter_en = (state_q == StMeas) || (state_q == StRun);

    pll_freq_meter #(
        .WinCyc  (WIN_CYC),
        .ExpEdges(EXP_EDGES),
        .Tol     (TOL)
    ) u_freq_meter (
        .clk_out0  (clk_out0),
        .arst_n    (arst_n),
        .en_i      (meter_en),
        .tgl_i     (clk_mon_tgl),
        .win_done_o(win_done),
        .win_pass_o(win_pass),
        .count_o   (win_count)
    );
`else
    localparam bit MonEn = 1'b0;
    logic unused_mon;

    // No monitor: windows never end, so the retry/fault path is unreachable.
    assign unused_mon = ^{clk_mon_tgl, WIN_CYC[0], EXP_EDGES[0], TOL[0]};
    assign win_done   = 1'b0;
    assign win_pass   = 1'b1;
    assign win_count  = '0;
`endif

    // Next state, phase counter, retry bookkeeping and registered output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CntW'(1);
        retry_d    = retry_q;
        meas_d     = meas_q;
        srst_d     = '1;
        fail_state = (retry_q == 2'(MAX_RETRY)) ? StFault : StPllRst;

        // The result register tracks every completed window, even if lock is lost with it.
        if (win_done) begin
            meas_d = win_count;
        end

        unique case (state_q)
            StWaitLock: begin
                if (lock_s_q) state_d = StStab;
            end
            StStab: begin
                if (!lock_s_q) state_d = StWaitLock;
                else if (cnt_q == CntW'(STAB_CYC - 1)) state_d = MonEn ? StMeas : StRel;
            end
            StMeas: begin
                if (!lock_s_q) state_d = StWaitLock;
                else if (win_done) state_d = win_pass ? StRel : fail_state;
            end
            StRel: begin
                if (!lock_s_q) state_d = StWaitLock;
                else if (cnt_q == CntW'((N_DOM - 1) * STAGE_GAP)) state_d = StRun;
            end
            StRun: begin
                if (!lock_s_q) state_d = StWaitLock;
                else if (win_done && !win_pass) state_d = fail_state;
            end
            StPllRst: begin
                if (cnt_q == CntW'(GUARD_CYC - 1)) state_d = StWaitLock;
            end
            StFault: begin
                if (clr_fault) begin
                    retry_d = '0;
                    state_d = StPllRst;
                end
            end
            default: state_d = StWaitLock;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
        if (state_d == StPllRst && (state_q == StMeas || state_q == StRun)) begin
            retry_d = retry_q + 2'd1;
        end

        // Outputs follow the state being entered so they are valid from its first cycle.
        if (state_d == StRel) begin
            for (int unsigned i = 0; i < N_DOM; i++) begin
                srst_d[i] = cnt_d < CntW'(i * STAGE_GAP);
            end
        end else if (state_d == StRun) begin
            srst_d = '0;
        end
        ready_d = (state_d == StRun);
        req_d   = (state_d == StPllRst) && (state_q != StPllRst);
        fault_d = (state_d == StFault);
    end

    // State, counter and output registers.
    always_ff @(posedge clk_out0 or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            srst_q  <= '1;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
            retry_q <= '0;
            meas_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            srst_q  <= srst_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            fault_q <= fault_d;
            retry_q <= retry_d;
            meas_q  <= meas_d;
        end
    end

    assign srst_o      = srst_q;
    assign ready       = ready_q;
    assign pll_rst_req = req_q;
    assign fault       = fault_q;
    assign retry_cnt   = retry_q;
    assign meas_cnt    = meas_q;

endmodule
